// File: rtl/instr_fetch.sv
// Instruction-fetch front end: program counter, word-addressed instruction memory
// with a pre-run load port, and next-PC selection from branch/jump decisions.
module instr_fetch #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          stall,
    input  logic          branch,
    input  logic          zero,
    input  logic          jump,
    output logic [31:0]   instruction,
    output logic [31:0]   pc,
    output logic [31:0]   pc_plus4,
    output logic          valid,
    output logic          halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [31:0] MEM_BYTES = 32'(IMEM_DEPTH) << 2;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_imem [IMEM_DEPTH];
    logic        w_pc_ok;
    logic [31:0] w_word;
    logic        w_fault;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_jmp_tgt;

    // Fetch address decode; an unusable PC never indexes the memory.
    always_comb begin
        w_pc_ok    = (r_pc < MEM_BYTES) && (r_pc[1:0] == 2'b00);
        if (w_pc_ok) begin
            w_word = r_imem[r_pc[AW+1:2]];
        end else begin
            w_word = 32'h0000_0000;
        end
        w_fault    = !w_pc_ok || (w_word == HALT_WORD);
        w_pc_plus4 = r_pc + 32'd4;
        w_br_off   = {{14{w_word[15]}}, w_word[15:0], 2'b00};
        w_jmp_tgt  = {w_pc_plus4[31:28], w_word[25:0], 2'b00};
    end

    // Next-state and next-PC selection; jump outranks a taken branch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_IDLE: begin
                if (!load_en) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_fault) begin
                    w_state_nxt = ST_HALT;
                end else if (jump) begin
                    w_pc_nxt = w_jmp_tgt;
                end else if (branch && zero) begin
                    w_pc_nxt = w_pc_plus4 + w_br_off;
                end else begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = RESET_PC;
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Program load; contents deliberately survive reset so a rerun needs no reload.
    always_ff @(posedge clk) begin
        if ((r_state == ST_IDLE) && load_en) begin
            r_imem[load_addr] <= load_data;
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instruction = (r_state == ST_RUN) ? w_word : 32'h0000_0000;
    assign valid       = (r_state == ST_RUN) && !stall;
    assign halted      = (r_state == ST_HALT);

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch front end for the single-cycle MIPS core: holds the program counter and a word-addressed instruction memory, and drives `instruction` into the controller and datapath every cycle. It consumes the controller's `branch` and `jump` decisions plus the datapath's ALU zero flag to select the next PC. It replaces hand-driven instruction stimulus so that whole programs can run on the core. A load port fills the memory before execution starts.

## Interface
- `IMEM_DEPTH`, 256: instruction memory depth in 32-bit words; must be a power of two. `AW = $clog2(IMEM_DEPTH)`.
- `RESET_PC`, 32'h0000_0000: PC value after reset; must be word-aligned.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops fetch.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  memory write strobe; honoured only in IDLE.
- `load_addr`  in  AW  word index for the load write.
- `load_data`  in  32  word to write.
- `stall`  in  1  hold the PC and the current instruction.
- `branch`  in  1  controller branch decode for the current instruction.
- `zero`  in  1  datapath ALU zero flag for the current instruction.
- `jump`  in  1  controller jump decode for the current instruction.
- `instruction`  out  32  instruction to the controller and datapath; 0 (NOP) unless in RUN.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `valid`  out  1  high in RUN when `stall` is low.
- `halted`  out  1  high in HALT.

## Operation
- FSM states: IDLE, RUN, HALT.
  - IDLE → RUN on the first edge where `load_en` = 0.
  - RUN → HALT on an edge where `stall` = 0 and the fetch fault condition is true.
  - HALT is absorbing; only `rst` leaves it.
- Fetch fault, evaluated on the current PC: `imem[pc[AW+1:2]] == HALT_WORD`, or `pc >= IMEM_DEPTH*4`, or `pc[1:0] != 0`.
- IDLE: on each edge with `load_en` = 1, `imem[load_addr] <= load_data`. `load_en` is ignored in RUN and HALT.
- RUN:
  - `instruction = imem[pc[AW+1:2]]`, read combinationally.
  - On an out-of-range or misaligned PC, `instruction` = 0 and memory is not indexed.
- Next PC, on an edge in RUN with `stall` = 0 and no fault, in priority order:
  1. `jump` = 1: `{pc_plus4[31:28], instruction[25:0], 2'b00}`.
  2. `branch & zero`: `pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00}`, wrapping modulo 2^32.
  3. Otherwise: `pc_plus4`.
- `branch` with `zero` = 0 is not taken. `jump` wins over a simultaneous taken branch.
- `stall` = 1 in RUN: PC and `instruction` hold; `branch`, `jump` and `zero` are ignored.
- On the edge entering HALT, the PC does not update; it keeps the faulting address.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values, applied asynchronously while `rst` = 0:
  - state = IDLE, `pc` = `RESET_PC`, `pc_plus4` = `RESET_PC + 4`;
  - `instruction` = 0, `valid` = 0, `halted` = 0.
- A reset asserted mid-RUN or in HALT returns to IDLE immediately. Program contents are retained, so a rerun needs no reload.
- The first valid instruction appears in the cycle after the IDLE → RUN edge.
- Latency: the PC changes exactly one edge after its control inputs are sampled. The new `instruction` is valid combinationally in the same cycle as the new PC.
- `branch`, `jump` and `zero` must be settled before the rising edge; they are combinational from `instruction`.
- `halted` and `valid` are derived from the registered state and have no combinational path from `stall`. Exception: `valid` = state==RUN & ~`stall`.
- A load issued on the same edge as the IDLE → RUN transition cannot occur, because the transition requires `load_en` = 0.

## Test plan
- **Sequential fetch:** load `imem[0..2]` = 0x00221820, 0x00000000, `HALT_WORD`; release `load_en` → `pc` = 0, 4, 8 on consecutive cycles, `valid` = 1, then `halted` = 1 with `pc` held at 8.
- **Branch taken and not taken:** `imem[0]` = 0x10640003 with `branch` = 1.
  - `zero` = 1 → next `pc` = 0x10.
  - `zero` = 0 → next `pc` = 0x4.
  - With `imm` = 0xFFFF at `pc` = 8 and taken → next `pc` = 8.
- **Jump priority:** `imem[0]` = 0x08000004 with `jump` = 1 and `branch` = `zero` = 1 → next `pc` = 0x10.
- **Stall:** assert `stall` for 3 cycles at `pc` = 4 → `pc` and `instruction` unchanged, `valid` = 0, and `jump` pulses are ignored. On release, fetch resumes from 4.
- **Out-of-range:** `IMEM_DEPTH` = 4 with no `HALT_WORD` loaded → `pc` reaches 0x10, `instruction` = 0, and `halted` = 1 on the next edge.
- **Reset mid-run:** drop `rst` at `pc` = 8, between clock edges → `pc` = `RESET_PC`, `instruction` = 0 and `valid` = 0 immediately. After release, the same program reruns without reloading.
